// File: rtl/selec_loader_pkg.sv
// Shared widths, field offsets, state encoding and types for the selection-word loader
// and the data_selector that slices its output.
package selec_loader_pkg;

  localparam int unsigned MAIN_INPUTS     = 16;
  localparam int unsigned REGS_INPUTS     = 64;
  localparam int unsigned OUTPUTS         = 4;
  localparam int unsigned OUTPUTS_PER_BUS = 4;

  localparam int unsigned MW      = $clog2(MAIN_INPUTS);
  localparam int unsigned RW      = $clog2(REGS_INPUTS);
  localparam int unsigned SLOTS   = OUTPUTS * OUTPUTS_PER_BUS;
  localparam int unsigned FIELD_W = 1 + MW + RW;
  localparam int unsigned SELEC_W = SLOTS * FIELD_W;
  localparam int unsigned SW      = $clog2(SLOTS);
  localparam int unsigned CW      = SW + 1;

  // Bit offsets of each sub-field inside one slot field
  localparam int unsigned ORIGIN_LSB = 0;
  localparam int unsigned MAIN_LSB   = 1;
  localparam int unsigned REGS_LSB   = 1 + MW;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  typedef struct packed {
    logic [RW-1:0] regs;
    logic [MW-1:0] main;
    logic          origin;
  } selecFieldT;

  typedef struct packed {
    logic [SW-1:0] slot;
    selecFieldT    field;
    logic          last;
  } selecEntryT;

  // Entry counter increment that sticks at SLOTS
  function automatic logic [CW-1:0] satInc(input logic [CW-1:0] count);
    return (count >= CW'(SLOTS)) ? count : count + CW'(1);
  endfunction

endpackage

// File: rtl/selec_field_pack.sv
// Packs origin/main/regs into one slot field of the selection word.
module selec_field_pack
  import selec_loader_pkg::*;
(
  input  logic               origin,
  input  logic [MW-1:0]      main,
  input  logic [RW-1:0]      regs,
  output logic [FIELD_W-1:0] fieldC
);

  always_comb begin
    fieldC                    = '0;
    fieldC[ORIGIN_LSB]        = origin;
    fieldC[MAIN_LSB +: MW]    = main;
    fieldC[REGS_LSB +: RW]    = regs;
  end

endmodule

// File: rtl/selec_loader.sv
// Streams per-slot selector entries into a shadow word and commits it atomically
// to the active selection word, flagging busy while a load is in flight.
module selec_loader
  import selec_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wInValid,
  output logic               wInReady,
  input  logic [SW-1:0]      wInSlot,
  input  logic               wInOrigin,
  input  logic [MW-1:0]      wInMain,
  input  logic [RW-1:0]      wInRegs,
  input  logic               wInLast,
  input  logic               wAbort,
  output logic [SELEC_W-1:0] wSelec,
  output logic               wBusy,
  output logic               wDone,
  output logic [CW-1:0]      wCount
);

  logic [1:0]         state;
  logic [1:0]         stateNext;
  logic [SELEC_W-1:0] shadow;
  logic [SELEC_W-1:0] shadowNext;
  logic [SELEC_W-1:0] selecNext;
  logic               busyNext;
  logic               doneNext;
  logic [CW-1:0]      countNext;
  logic               accept;
  logic               loadWr;
  logic [FIELD_W-1:0] packedField;

  selec_field_pack uPack (
    .origin (wInOrigin),
    .main   (wInMain),
    .regs   (wInRegs),
    .fieldC (packedField)
  );

  // Abort wins over an offered entry, so the two never land on the same edge
  assign wInReady = !rst && (state != COMMIT) && !wAbort;
  assign accept   = wInValid && wInReady;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      shadow <= '0;
      wSelec <= '0;
      wBusy  <= 1'b0;
      wDone  <= 1'b0;
      wCount <= '0;
    end else begin
      state  <= stateNext;
      shadow <= shadowNext;
      wSelec <= selecNext;
      wBusy  <= busyNext;
      wDone  <= doneNext;
      wCount <= countNext;
    end
  end

  always_comb begin
    stateNext  = state;
    shadowNext = shadow;
    selecNext  = wSelec;
    busyNext   = wBusy;
    doneNext   = 1'b0;
    countNext  = wCount;
    loadWr     = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          loadWr    = 1'b1;
          stateNext = wInLast ? COMMIT : LOAD;
        end
      end
      LOAD: begin
        // Abort restores the shadow to the active word so the next load starts clean
        if (wAbort) begin
          stateNext  = IDLE;
          shadowNext = wSelec;
          countNext  = '0;
          busyNext   = 1'b0;
        end else if (accept) begin
          loadWr = 1'b1;
          if (wInLast) begin
            stateNext = COMMIT;
          end
        end
      end
      COMMIT: begin
        stateNext = IDLE;
        selecNext = shadow;
        doneNext  = 1'b1;
        countNext = '0;
        busyNext  = 1'b0;
      end
      default: begin
        stateNext = IDLE;
        busyNext  = 1'b0;
      end
    endcase

    // Out-of-range slot indices match no field and are dropped, but still counted
    if (loadWr) begin
      for (int k = 0; k < SLOTS; k++) begin
        if (wInSlot == SW'(k)) begin
          shadowNext[k*FIELD_W +: FIELD_W] = packedField;
        end
      end
      countNext = satInc(wCount);
      busyNext  = 1'b1;
    end
  end

endmodule

// File: tb/tb_selec_loader.sv
// Directed self-checking bench for selec_loader.
module tb_selec_loader;
  import selec_loader_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               wInValid;
  logic               wInReady;
  logic [SW-1:0]      wInSlot;
  logic               wInOrigin;
  logic [MW-1:0]      wInMain;
  logic [RW-1:0]      wInRegs;
  logic               wInLast;
  logic               wAbort;
  logic [SELEC_W-1:0] wSelec;
  logic               wBusy;
  logic               wDone;
  logic [CW-1:0]      wCount;

  int total = 0;
  int bad   = 0;
  logic [FIELD_W-1:0] mdl [SLOTS];

  always #5 clk = ~clk;

  selec_loader dut (
    .clk       (clk),
    .rst       (rst),
    .wInValid  (wInValid),
    .wInReady  (wInReady),
    .wInSlot   (wInSlot),
    .wInOrigin (wInOrigin),
    .wInMain   (wInMain),
    .wInRegs   (wInRegs),
    .wInLast   (wInLast),
    .wAbort    (wAbort),
    .wSelec    (wSelec),
    .wBusy     (wBusy),
    .wDone     (wDone),
    .wCount    (wCount)
  );

  task automatic check(input string tag, input logic [SELEC_W-1:0] obs, input logic [SELEC_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FIELD_W-1:0] fld(input logic o, input int m, input int r);
    return {RW'(r), MW'(m), o};
  endfunction

  function automatic logic [SELEC_W-1:0] expWord();
    logic [SELEC_W-1:0] w;
    w = '0;
    for (int k = 0; k < SLOTS; k++) w[k*FIELD_W +: FIELD_W] = mdl[k];
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int slot, input logic o, input int m, input int r, input logic last);
    wInValid  = 1'b1;
    wInSlot   = SW'(slot);
    wInOrigin = o;
    wInMain   = MW'(m);
    wInRegs   = RW'(r);
    wInLast   = last;
    tick();
  endtask

  task automatic idle();
    wInValid = 1'b0;
    wInLast  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wInValid = 1'b0; wInSlot = '0; wInOrigin = 1'b0;
    wInMain = '0; wInRegs = '0; wInLast = 1'b0; wAbort = 1'b0;
    for (int k = 0; k < SLOTS; k++) mdl[k] = '0;
    tick(); tick();
    check("rst_selec", wSelec, '0);
    check("rst_busy", SELEC_W'(wBusy), SELEC_W'(0));
    check("rst_done", SELEC_W'(wDone), SELEC_W'(0));
    check("rst_count", SELEC_W'(wCount), SELEC_W'(0));
    check("rst_ready", SELEC_W'(wInReady), SELEC_W'(0));
    rst = 1'b0;
    #1;
    check("idle_ready", SELEC_W'(wInReady), SELEC_W'(1));

    // Single entry with last: commit one cycle after acceptance
    send(3, 1'b1, 5, 42, 1'b1);
    idle();
    check("t1_e0_busy", SELEC_W'(wBusy), SELEC_W'(1));
    check("t1_e0_ready", SELEC_W'(wInReady), SELEC_W'(0));
    check("t1_e0_selec", wSelec, '0);
    check("t1_e0_done", SELEC_W'(wDone), SELEC_W'(0));
    tick();
    mdl[3] = fld(1'b1, 5, 42);
    check("t1_slot3", SELEC_W'(wSelec[43:33]), SELEC_W'(11'h54B));
    check("t1_word", wSelec, expWord());
    check("t1_e1_done", SELEC_W'(wDone), SELEC_W'(1));
    check("t1_e1_busy", SELEC_W'(wBusy), SELEC_W'(0));
    tick();
    check("t1_e2_done", SELEC_W'(wDone), SELEC_W'(0));

    // Full 16-entry load
    for (int k = 0; k < 15; k++) send(k, k[0], k, 63 - k, 1'b0);
    check("t2_mid_selec", wSelec, expWord());
    check("t2_mid_count", SELEC_W'(wCount), SELEC_W'(15));
    check("t2_mid_busy", SELEC_W'(wBusy), SELEC_W'(1));
    send(15, 1'b1, 15, 48, 1'b1);
    idle();
    check("t2_e0_count", SELEC_W'(wCount), SELEC_W'(16));
    check("t2_e0_selec", wSelec, expWord());
    check("t2_e0_done", SELEC_W'(wDone), SELEC_W'(0));
    tick();
    for (int k = 0; k < 16; k++) mdl[k] = fld(k[0], k, 63 - k);
    check("t2_commit", wSelec, expWord());
    check("t2_done", SELEC_W'(wDone), SELEC_W'(1));
    check("t2_count0", SELEC_W'(wCount), SELEC_W'(0));
    tick();

    // Duplicate slot: last write wins, other slots retained
    send(2, 1'b0, 0, 1, 1'b0);
    send(2, 1'b0, 0, 9, 1'b1);
    idle();
    tick();
    mdl[2] = fld(1'b0, 0, 9);
    check("t3_regs2", SELEC_W'(wSelec[2*FIELD_W+REGS_LSB +: RW]), SELEC_W'(9));
    check("t3_word", wSelec, expWord());
    tick();

    // Abort after three entries
    send(0, 1'b1, 7, 7, 1'b0);
    send(1, 1'b1, 7, 7, 1'b0);
    send(5, 1'b1, 7, 7, 1'b0);
    wAbort = 1'b1;
    #1;
    check("t4_ready_abort", SELEC_W'(wInReady), SELEC_W'(0));
    tick();
    wAbort = 1'b0;
    idle();
    check("t4_selec", wSelec, expWord());
    check("t4_busy", SELEC_W'(wBusy), SELEC_W'(0));
    check("t4_count", SELEC_W'(wCount), SELEC_W'(0));
    check("t4_done", SELEC_W'(wDone), SELEC_W'(0));
    tick();
    check("t4_done2", SELEC_W'(wDone), SELEC_W'(0));
    send(7, 1'b0, 3, 17, 1'b1);
    idle();
    tick();
    mdl[7] = fld(1'b0, 3, 17);
    check("t4_after", wSelec, expWord());
    tick();

    // Reset in the middle of a load
    for (int k = 8; k < 13; k++) send(k, 1'b1, 1, 1, 1'b0);
    idle();
    check("t5_count", SELEC_W'(wCount), SELEC_W'(5));
    rst = 1'b1;
    tick();
    check("t5_selec", wSelec, '0);
    check("t5_busy", SELEC_W'(wBusy), SELEC_W'(0));
    check("t5_ready", SELEC_W'(wInReady), SELEC_W'(0));
    check("t5_count0", SELEC_W'(wCount), SELEC_W'(0));
    rst = 1'b0;
    for (int k = 0; k < SLOTS; k++) mdl[k] = '0;
    send(15, 1'b1, 15, 63, 1'b1);
    idle();
    tick();
    mdl[15] = fld(1'b1, 15, 63);
    check("t5_after", wSelec, expWord());
    tick();

    // Valid held through a commit
    send(4, 1'b0, 1, 2, 1'b1);
    wInSlot = SW'(6); wInOrigin = 1'b1; wInMain = MW'(9); wInRegs = RW'(33);
    #1;
    check("t6_ready_commit", SELEC_W'(wInReady), SELEC_W'(0));
    tick();
    mdl[4] = fld(1'b0, 1, 2);
    check("t6_first", wSelec, expWord());
    check("t6_done", SELEC_W'(wDone), SELEC_W'(1));
    check("t6_ready_done", SELEC_W'(wInReady), SELEC_W'(1));
    tick();
    idle();
    check("t6_busy_again", SELEC_W'(wBusy), SELEC_W'(1));
    check("t6_done_low", SELEC_W'(wDone), SELEC_W'(0));
    check("t6_hold", wSelec, expWord());
    tick();
    mdl[6] = fld(1'b1, 9, 33);
    check("t6_second", wSelec, expWord());
    check("t6_done2", SELEC_W'(wDone), SELEC_W'(1));
    tick();

    // Count saturation, then abort
    for (int k = 0; k < 17; k++) send(k % 16, 1'b0, 2, 2, 1'b0);
    idle();
    check("t7_sat", SELEC_W'(wCount), SELEC_W'(16));
    wAbort = 1'b1;
    tick();
    wAbort = 1'b0;
    check("t7_count0", SELEC_W'(wCount), SELEC_W'(0));
    check("t7_selec", wSelec, expWord());
    check("t7_busy", SELEC_W'(wBusy), SELEC_W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
